// File: rtl/uart_pkg.sv
// Shared UART types and default constants.
//   uart_tx_state_t   : transmit FSM states
//   UART_DATA_WIDTH   : default data bits per frame
//   UART_CLKS_PER_BIT : default clk cycles per bit period
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH   = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 1231;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line between a message sequencer and the
// UART transmit serializer.
//   start     : sequencer request to send din_tx
//   din_tx    : byte to send
//   serial_tx : serial line, idle high
//   busy      : frame in progress
//   done      : one-cycle frame-complete pulse
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) ();

  logic                  start;
  logic [DATA_WIDTH-1:0] din_tx;
  logic                  serial_tx;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output din_tx,
    input  serial_tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  din_tx,
    output serial_tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, raising bit_tick
// for the single cycle in which the count equals CLKS_PER_BIT-1.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous restart of the count at 0
//   bit_tick : registered one-cycle end-of-bit strobe
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: restart on clear, wrap after the last count of a bit.
  always_comb begin
    cnt_nxt = '0;
    if (!clear && (cnt_q != CNT_LAST)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  // Tick is registered from the next count so it lines up with cnt_q == last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      bit_tick <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte per start handshake while idle
// and sends it as an 8N1 frame (start bit, data LSB first, stop bit).
// A start seen in the done cycle is accepted, so frames can run back-to-back.
//   clk     : system clock
//   reset_n : asynchronous active-low reset; aborts any frame, line to idle
//   bus     : slave side of uart_tx_serializer_if (start/din_tx in,
//             serial_tx/busy/done out, all outputs registered)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_tx_serializer_if.slave   bus
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_t        state_q;
  uart_tx_state_t        state_nxt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  tx_q;
  logic                  tx_nxt;
  logic                  busy_q;
  logic                  busy_nxt;
  logic                  done_q;
  logic                  done_nxt;
  logic                  baud_clear;
  logic                  bit_tick;

  // Bit timer is held at zero while idle, so every frame starts on a fresh period.
  assign baud_clear = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      idx_q   <= idx_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    idx_nxt   = idx_q;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_nxt = bus.din_tx;
          idx_nxt   = '0;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_tick) begin
          state_nxt = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (bit_tick) begin
          shift_nxt = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = STOP_BIT;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Line level is decoded from the upcoming state so it is registered in step.
    case (state_nxt)
      START_BIT: tx_nxt = 1'b0;
      DATA_BITS: tx_nxt = shift_nxt[0];
      default:   tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.serial_tx = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4, DATA_WIDTH=8.
module tb_uart_tx_serializer;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
  localparam int          FRAME_CYC = (DW + 2) * CPB;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle line for n cycles: tx=1, busy=0, done=0.
  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({bus.serial_tx, bus.busy, bus.done} !== 3'b100) begin
        errors++;
        $display("FAIL %s cycle=%0d tx/busy/done got=%b exp=100", name, i,
                 {bus.serial_tx, bus.busy, bus.done});
      end
      step();
    end
  endtask

  // Entry: cycle 1 after the accepting edge. Exit: cycle 41 (done cycle).
  // pulse_at != 0 raises start with din_tx=FF for one cycle mid-frame.
  task automatic check_frame(input logic [7:0] b, input int pulse_at, input string name);
    logic [9:0] fb;
    logic       exp_bit;
    fb = {1'b1, b, 1'b0};
    for (int k = 1; k <= FRAME_CYC; k++) begin
      if (pulse_at != 0 && k == pulse_at) begin
        bus.start  = 1'b1;
        bus.din_tx = 8'hFF;
      end else if (pulse_at != 0 && k == pulse_at + 1) begin
        bus.start = 1'b0;
      end
      exp_bit = fb[(k - 1) / CPB];
      checks++;
      if ({bus.serial_tx, bus.busy, bus.done} !== {exp_bit, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s k=%0d tx/busy/done got=%b exp=%b", name, k,
                 {bus.serial_tx, bus.busy, bus.done}, {exp_bit, 2'b10});
      end
      step();
    end
    checks++;
    if ({bus.serial_tx, bus.busy, bus.done} !== 3'b101) begin
      errors++;
      $display("FAIL %s_done k=41 tx/busy/done got=%b exp=101", name,
               {bus.serial_tx, bus.busy, bus.done});
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.din_tx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.serial_tx, bus.busy, bus.done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_values got=%b exp=100", {bus.serial_tx, bus.busy, bus.done});
    end
    reset_n = 1'b1;
    step();
    check_idle(20, "idle_after_reset");
  endtask

  task automatic test_single_frame();
    bus.start  = 1'b1;
    bus.din_tx = 8'h48;
    step();
    bus.start = 1'b0;
    check_frame(8'h48, 0, "single_H");
    step();
    check_idle(5, "single_after");
  endtask

  task automatic test_back_to_back();
    bus.start  = 1'b1;
    bus.din_tx = 8'h45;
    step();
    bus.din_tx = 8'h4C;
    check_frame(8'h45, 0, "b2b_E");
    step();
    check_frame(8'h4C, 0, "b2b_L");
    bus.start = 1'b0;
    step();
    check_idle(5, "b2b_after");
  endtask

  task automatic test_ignore_midframe();
    bus.start  = 1'b1;
    bus.din_tx = 8'h4F;
    step();
    bus.start = 1'b0;
    check_frame(8'h4F, 15, "mid_start_O");
    step();
    check_idle(10, "mid_start_no_second");
  endtask

  task automatic test_reset_midframe();
    bus.start  = 1'b1;
    bus.din_tx = 8'h41;
    step();
    bus.start = 1'b0;
    repeat (17) step();
    // Cycle 18 is inside data bit 3, which is 0 for 8'h41.
    checks++;
    if ({bus.serial_tx, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL pre_abort tx/busy got=%b exp=01", {bus.serial_tx, bus.busy});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.serial_tx, bus.busy, bus.done} !== 3'b100) begin
      errors++;
      $display("FAIL async_abort tx/busy/done got=%b exp=100",
               {bus.serial_tx, bus.busy, bus.done});
    end
    step();
    step();
    reset_n = 1'b1;
    check_idle(30, "abort_no_done");
    bus.start  = 1'b1;
    bus.din_tx = 8'h48;
    step();
    bus.start = 1'b0;
    check_frame(8'h48, 0, "after_abort_H");
    step();
  endtask

  task automatic test_hello();
    logic [7:0] msg [5];
    logic [9:0] rx;
    int         done_cnt;
    msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;
    done_cnt   = 0;
    bus.start  = 1'b1;
    bus.din_tx = msg[0];
    step();
    for (int i = 0; i < 5; i++) begin
      rx = '0;
      for (int k = 1; k <= FRAME_CYC; k++) begin
        if (k == 1) begin
          if (i < 4) bus.din_tx = msg[i + 1];
          else       bus.start  = 1'b0;
        end
        // Sample near the middle of each bit period.
        if ((k % CPB) == 2) rx[(k - 2) / CPB] = bus.serial_tx;
        step();
      end
      if (bus.done === 1'b1) done_cnt++;
      checks++;
      if (rx !== {1'b1, msg[i], 1'b0}) begin
        errors++;
        $display("FAIL hello_byte%0d got=%h exp=%h", i, rx, {1'b1, msg[i], 1'b0});
      end
      step();
    end
    checks++;
    if (done_cnt !== 5) begin
      errors++;
      $display("FAIL hello_done_count got=%0d exp=5", done_cnt);
    end
    check_idle(5, "hello_after");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_hello();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer of the UART path. It accepts one parallel byte per start/done handshake from a message sequencer, such as the "HELLO" character sender. It drives the byte onto `serial_tx` as an 8N1 frame: one start bit, DATA_WIDTH data bits LSB first, one stop bit, no parity. It is the stage directly downstream of the sequencer and upstream of the board TX pin. Back-to-back characters are supported with no idle gap.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 1231: clk cycles per bit period; must be ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  request to send `din_tx`; sampled only when `busy`=0.
- din_tx  input  DATA_WIDTH  byte to send; captured in the cycle `start` is accepted.
- serial_tx  output  1  serial line; idle high.
- busy  output  1  high from the cycle after acceptance until the frame ends.
- done  output  1  one-cycle pulse marking frame completion.

## Operation
- State machine (enum in package): IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - `serial_tx`=1 and `busy`=0.
  - If `start`=1, capture `din_tx` into the shift register, clear the baud and bit counters, and go to START_BIT.
- START_BIT:
  - `serial_tx`=0 for CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS:
  - `serial_tx` = shift_reg[0]; each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After bit index DATA_WIDTH-1 completes, go to STOP_BIT.
- STOP_BIT:
  - `serial_tx`=1 for CLKS_PER_BIT cycles, then go to IDLE with `done`=1 in that first IDLE cycle.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - A bit period ends when the baud counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - Bit index is $clog2(DATA_WIDTH) bits and counts 0..DATA_WIDTH-1.
  - The comparison is on the index value, never on overflow.
- `start` while `busy`=1 is ignored: no queueing, no frame corruption, and `din_tx` changes have no effect.
- Simultaneous `done` and `start` (first IDLE cycle): the start is accepted, so frames run back-to-back.
- `start` held high continuously resends the current `din_tx` each frame.
- Reset mid-frame:
  - `serial_tx` goes to 1 immediately, state goes to IDLE, and the frame is aborted.
  - No `done` is produced for the aborted frame.

## Timing
- Reset values: `serial_tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
- All outputs are registered, with no combinational path from `start` or `din_tx` to any output.
- Acceptance at edge N drives `serial_tx`=0 and `busy`=1 from edge N+1.
- Frame length is (DATA_WIDTH+2)×CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- `done` is high for exactly one cycle, coincident with `busy` falling.
- Minimum period between accepted starts = (DATA_WIDTH+2)×CLKS_PER_BIT + 1 cycles (the acceptance cycle).

## Structure
- `uart_pkg` holds:
  - `uart_tx_state_t` enum.
  - Default constants `UART_DATA_WIDTH`=8 and `UART_CLKS_PER_BIT`=1231.
- Sub-module `uart_baud_gen`:
  - Parameterized by CLKS_PER_BIT.
  - Inputs: `clk`, `reset_n`, synchronous `clear`.
  - Output: one-cycle `bit_tick` at count CLKS_PER_BIT-1.
  - Reused later by the receive path.
- The serializer instantiates one `uart_baud_gen` and owns the FSM, shift register and bit index.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
- Reset, then idle for 20 cycles -> `serial_tx`=1, `busy`=0, `done`=0 throughout.
- Single `start` pulse with `din_tx`=8'h48 ('H') -> line shows 0, then 0,0,0,1,0,0,1,0, then 1, each bit 4 cycles; `done` pulses at cycle 41 after acceptance.
- `start` held high with `din_tx` 8'h45, then 8'h4C -> second frame's start bit begins the cycle after `done`, with no idle-high bit between frames.
- `start` pulsed mid-frame with `din_tx` changed to 8'hFF -> the current frame is unchanged and no second frame follows.
- `reset_n` asserted during data bit 3 -> `serial_tx`=1 asynchronously, `busy`=0, no `done`; a new `start` after release sends a clean frame.
- Monitor decodes 5 back-to-back bytes "HELLO" -> receives 8'h48, 45, 4C, 4C, 4F and 5 `done` pulses.
